// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: in-order write-back buffer in front of the
// 32 x 32-bit register bank. Accepts requests over valid/ready, drains one
// entry per clock onto the bank write port, and flags read addresses that
// still have a write in flight so issue logic can stall.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_reg,
  input  logic [31:0]      in_data,
  input  logic             hold,
  output logic [4:0]       WriteReg,
  output logic [31:0]      WriteData,
  output logic             regWrite,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  output logic             hazard1,
  output logic             hazard2,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO   = (PTR_W + 1)'(0);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(0);

  // Entry storage; only slots inside [head, head+count) are meaningful.
  logic [4:0]       reg_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             wen_q, wen_d;

  logic             push_s;
  logic             enq_s;
  logic             pop_s;
  logic             hit1_s;
  logic             hit2_s;
  logic [PTR_W-1:0] off_s;

  // Handshake decode: ready comes from registered occupancy only, so a
  // same-cycle pop never opens the door for a push into a full queue.
  always_comb begin
    in_ready = (count_q != FULL_COUNT);
    push_s   = in_valid && in_ready;
    enq_s    = push_s && (in_reg != 5'd0);
    pop_s    = (count_q != CNT_ZERO) && !hold;
  end

  // Next-state for pointers, occupancy and the bank write-port registers.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;

    if (pop_s) begin
      head_d  = head_q + PTR_ONE;
      wreg_d  = reg_q[head_q];
      wdata_d = data_q[head_q];
      wen_d   = 1'b1;
    end else begin
      wen_d   = 1'b0;
    end

    if (enq_s) begin
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end

    if (enq_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!enq_s && pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Control and write-port registers; reset drops everything queued or in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= PTR_ZERO;
      tail_q  <= PTR_ZERO;
      count_q <= CNT_ZERO;
      wreg_q  <= 5'd0;
      wdata_q <= 32'd0;
      wen_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
    end
  end

  // Entry payload write at tail; occupancy gating makes a reset unnecessary.
  always_ff @(posedge clk) begin
    if (enq_s && !rst) begin
      reg_q[tail_q]  <= in_reg;
      data_q[tail_q] <= in_data;
    end
  end

  // Scan occupied slots (distance from head below count) for read-address matches.
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    off_s  = PTR_ZERO;
    for (int s = 0; s < DEPTH; s++) begin
      off_s = PTR_W'(s) - head_q;
      if ({1'b0, off_s} < count_q) begin
        if (reg_q[s] == ReadReg1) begin
          hit1_s = 1'b1;
        end else begin
          hit1_s = hit1_s;
        end
        if (reg_q[s] == ReadReg2) begin
          hit2_s = 1'b1;
        end else begin
          hit2_s = hit2_s;
        end
      end else begin
        hit1_s = hit1_s;
        hit2_s = hit2_s;
      end
    end
  end

  // Hazards also cover the write sitting in the output register until the bank captures it.
  always_comb begin
    hazard1 = (ReadReg1 != 5'd0) && (hit1_s || (wen_q && (wreg_q == ReadReg1)));
    hazard2 = (ReadReg2 != 5'd0) && (hit2_s || (wen_q && (wreg_q == ReadReg2)));
  end

  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;
  assign regWrite  = wen_q;
  assign count     = count_q;

endmodule
